// File: rtl/score_keeper_if.sv
// score_keeper_if: game-control inputs and scoreboard/ball-control outputs of score_keeper.
interface score_keeper_if;
   logic       frame_tick;
   logic       start;
   logic       goal_player;
   logic       goal_ai;
   logic [3:0] player_score;
   logic [3:0] ai_score;
   logic       serve;
   logic       serve_dir;
   logic       freeze;
   logic       game_over;
   logic       winner;
   modport master (output frame_tick, start, goal_player, goal_ai,
                   input player_score, ai_score, serve, serve_dir, freeze, game_over, winner);
   modport slave  (input frame_tick, start, goal_player, goal_ai,
                   output player_score, ai_score, serve, serve_dir, freeze, game_over, winner);
endinterface

// File: rtl/score_keeper.sv
// score_keeper: pong game sequencer; tracks scores, times the pause before each serve,
// and declares a winner when either side reaches WIN_SCORE.
module score_keeper #(
   parameter int WIN_SCORE    = 9,
   parameter int PAUSE_FRAMES = 60
) (
   input  logic         VGA_CLK,
   input  logic         resetn,
   score_keeper_if.slave sk
);
   typedef enum logic [2:0] {IDLE, PAUSE, SERVE, PLAY, OVER} state_t;

   localparam logic [3:0] WIN = 4'(WIN_SCORE);
   localparam logic [7:0] PF  = 8'(PAUSE_FRAMES);

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [3:0] p_q, p_d, a_q, a_d;
   logic       serve_q, serve_d, dir_q, dir_d, freeze_q, freeze_d;
   logic       over_q, over_d, win_q, win_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      p_d     = p_q;
      a_d     = a_q;
      dir_d   = dir_q;
      win_d   = win_q;
      serve_d = 1'b0;
      case (state_q)
         IDLE:
            if (sk.start) begin
               p_d     = '0;
               a_d     = '0;
               cnt_d   = '0;
               state_d = PAUSE;
            end
         PAUSE:
            if (sk.frame_tick) begin
               cnt_d = cnt_q + 8'd1;
               if (cnt_q + 8'd1 == PF) begin
                  state_d = SERVE;
                  serve_d = 1'b1;
               end
            end
         SERVE: state_d = PLAY;
         PLAY: begin
            // any goal restarts the pause from zero, so a coincident frame_tick is not counted
            if (sk.goal_player || sk.goal_ai) begin
               cnt_d   = '0;
               state_d = PAUSE;
            end
            if (sk.goal_player && !sk.goal_ai) begin
               p_d   = p_q + 4'd1;
               dir_d = 1'b1;
               if (p_q + 4'd1 == WIN) begin
                  state_d = OVER;
                  win_d   = 1'b1;
               end
            end else if (sk.goal_ai && !sk.goal_player) begin
               a_d   = a_q + 4'd1;
               dir_d = 1'b0;
               if (a_q + 4'd1 == WIN) begin
                  state_d = OVER;
                  win_d   = 1'b0;
               end
            end
         end
         OVER:
            if (sk.start) begin
               p_d     = '0;
               a_d     = '0;
               cnt_d   = '0;
               win_d   = 1'b0;
               dir_d   = 1'b0;
               state_d = PAUSE;
            end
         default: state_d = IDLE;
      endcase
      freeze_d = state_d != PLAY;
      over_d   = state_d == OVER;
   end

   always_ff @(posedge VGA_CLK) begin
      if (!resetn) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         p_q      <= '0;
         a_q      <= '0;
         serve_q  <= 1'b0;
         dir_q    <= 1'b0;
         freeze_q <= 1'b1;
         over_q   <= 1'b0;
         win_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         p_q      <= p_d;
         a_q      <= a_d;
         serve_q  <= serve_d;
         dir_q    <= dir_d;
         freeze_q <= freeze_d;
         over_q   <= over_d;
         win_q    <= win_d;
      end
   end

   assign sk.player_score = p_q;
   assign sk.ai_score     = a_q;
   assign sk.serve        = serve_q;
   assign sk.serve_dir    = dir_q;
   assign sk.freeze       = freeze_q;
   assign sk.game_over    = over_q;
   assign sk.winner       = win_q;
endmodule
